wbi_slave_port: RTL and testbench

Terminal responder for the wishbone interconnect command/response daisy chain. It accepts command beats on the valid/ready command channel and executes them as classic Wishbone cycles on one local slave, with read and write bursts expanded into single accesses. It returns one tagged response beat per access on the valid/ready response channel. It sits at the far end of a chain of staging registers, directly in front of a peripheral or memory controller.

---
 rtl/wbi_slave_port_if.sv | 53 +++++
 rtl/wbi_slave_port.sv | 200 ++++++++++++++++++++
 tb/tb_wbi_slave_port.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbi_slave_port_if.sv
// Command/response daisy-chain channels plus the local Wishbone slave bus of wbi_slave_port.
// The slave modport is the port side; master is the driving/observing side.
interface wbi_slave_port_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned BW = 4,
    parameter int unsigned BL = 10,
    parameter int unsigned DW = 32
) ();
    logic          wbd_cmd_wval_i;
    logic          wbd_cmd_wrdy_o;
    logic [AW-1:0] wbd_cmd_adr_i;
    logic          wbd_cmd_we_i;
    logic [DW-1:0] wbd_cmd_dat_i;
    logic [BW-1:0] wbd_cmd_sel_i;
    logic [3:0]    wbd_cmd_tid_i;
    logic [BL-1:0] wbd_cmd_bl_i;

    logic          wbd_res_rval_o;
    logic          wbd_res_rrdy_i;
    logic [DW-1:0] wbd_res_dat_o;
    logic          wbd_res_ack_o;
    logic          wbd_res_lack_o;
    logic          wbd_res_err_o;
    logic [3:0]    wbd_res_tid_o;

    logic          wbs_cyc_o;
    logic          wbs_stb_o;
    logic [AW-1:0] wbs_adr_o;
    logic          wbs_we_o;
    logic [DW-1:0] wbs_dat_o;
    logic [BW-1:0] wbs_sel_o;
    logic [DW-1:0] wbs_dat_i;
    logic          wbs_ack_i;
    logic          wbs_err_i;

    modport slave (
        input  wbd_cmd_wval_i, wbd_cmd_adr_i, wbd_cmd_we_i, wbd_cmd_dat_i,
               wbd_cmd_sel_i, wbd_cmd_tid_i, wbd_cmd_bl_i, wbd_res_rrdy_i,
               wbs_dat_i, wbs_ack_i, wbs_err_i,
        output wbd_cmd_wrdy_o, wbd_res_rval_o, wbd_res_dat_o, wbd_res_ack_o,
               wbd_res_lack_o, wbd_res_err_o, wbd_res_tid_o,
               wbs_cyc_o, wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o
    );

    modport master (
        output wbd_cmd_wval_i, wbd_cmd_adr_i, wbd_cmd_we_i, wbd_cmd_dat_i,
               wbd_cmd_sel_i, wbd_cmd_tid_i, wbd_cmd_bl_i, wbd_res_rrdy_i,
               wbs_dat_i, wbs_ack_i, wbs_err_i,
        input  wbd_cmd_wrdy_o, wbd_res_rval_o, wbd_res_dat_o, wbd_res_ack_o,
               wbd_res_lack_o, wbd_res_err_o, wbd_res_tid_o,
               wbs_cyc_o, wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o
    );
endinterface

// File: rtl/wbi_slave_port.sv
// Chain-terminating responder: runs command beats as single classic Wishbone accesses and returns one response per access.
// Optional WB_REQ watchdog enabled by defining WBI_SLV_TIMEOUT_EN.
module wbi_slave_port #(
    parameter int unsigned AW = 32,
    parameter int unsigned BW = 4,
    parameter int unsigned BL = 10,
    parameter int unsigned DW = 32
) (
    input  logic             mclk,
    input  logic             reset_n,
    wbi_slave_port_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB_REQ = 3'd1;
    localparam logic [2:0] S_RESP   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] adr_q,   adr_d;
    logic          we_q,    we_d;
    logic [BW-1:0] sel_q,   sel_d;
    logic [DW-1:0] wdat_q,  wdat_d;
    logic [3:0]    tid_q,   tid_d;
    logic [BL-1:0] rem_q,   rem_d;
    logic          cyc_q,   cyc_d;
    logic          rval_q,  rval_d;
    logic [DW-1:0] rdat_q,  rdat_d;
    logic          rack_q,  rack_d;
    logic          rlack_q, rlack_d;
    logic          rerr_q,  rerr_d;
    logic [3:0]    rtid_q,  rtid_d;

    logic cmd_acc_c;
    logic tmo_hit_c;
    logic term_err_c;

    // Command ready depends on state only; held low while reset is asserted
    assign bus.wbd_cmd_wrdy_o = reset_n &&
                                ((state_q == S_IDLE) || (state_q == S_WDATA) || (state_q == S_DRAIN));
    assign cmd_acc_c  = bus.wbd_cmd_wrdy_o && bus.wbd_cmd_wval_i;
    assign term_err_c = bus.wbs_err_i || tmo_hit_c;

`ifdef WBI_SLV_TIMEOUT_EN
    logic [7:0] tmo_q;

    // Watchdog: counts cycles spent in WB_REQ, zero on every entry
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= 8'd0;
        end else if (state_q == S_WB_REQ) begin
            tmo_q <= tmo_q + 8'd1;
        end else begin
            tmo_q <= 8'd0;
        end
    end

    assign tmo_hit_c = (state_q == S_WB_REQ) && (tmo_q == 8'hFF) &&
                       !bus.wbs_ack_i && !bus.wbs_err_i;
`else
    assign tmo_hit_c = 1'b0;
`endif

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            tid_q   <= 4'd0;
            rem_q   <= '0;
            cyc_q   <= 1'b0;
            rval_q  <= 1'b0;
            rdat_q  <= '0;
            rack_q  <= 1'b0;
            rlack_q <= 1'b0;
            rerr_q  <= 1'b0;
            rtid_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            tid_q   <= tid_d;
            rem_q   <= rem_d;
            cyc_q   <= cyc_d;
            rval_q  <= rval_d;
            rdat_q  <= rdat_d;
            rack_q  <= rack_d;
            rlack_q <= rlack_d;
            rerr_q  <= rerr_d;
            rtid_q  <= rtid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        tid_d   = tid_q;
        rem_d   = rem_q;
        cyc_d   = cyc_q;
        rval_d  = rval_q;
        rdat_d  = rdat_q;
        rack_d  = rack_q;
        rlack_d = rlack_q;
        rerr_d  = rerr_q;
        rtid_d  = rtid_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_acc_c) begin
                    adr_d   = bus.wbd_cmd_adr_i;
                    we_d    = bus.wbd_cmd_we_i;
                    sel_d   = bus.wbd_cmd_sel_i;
                    wdat_d  = bus.wbd_cmd_dat_i;
                    tid_d   = bus.wbd_cmd_tid_i;
                    rem_d   = (bus.wbd_cmd_bl_i == '0) ? BL'(1) : bus.wbd_cmd_bl_i;
                    cyc_d   = 1'b1;
                    state_d = S_WB_REQ;
                end
            end
            S_WB_REQ: begin
                // err (or watchdog expiry) overrides a simultaneous ack and ends the burst
                if (bus.wbs_ack_i || term_err_c) begin
                    rdat_d  = (!we_q && !tmo_hit_c) ? bus.wbs_dat_i : '0;
                    rack_d  = bus.wbs_ack_i && !term_err_c;
                    rerr_d  = term_err_c;
                    rlack_d = (rem_q == BL'(1)) || term_err_c;
                    rtid_d  = tid_q;
                    rval_d  = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.wbd_res_rrdy_i) begin
                    rval_d = 1'b0;
                    if (rlack_q) begin
                        if (we_q && (rem_q > BL'(1))) begin
                            rem_d   = rem_q - BL'(1);
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        rem_d = rem_q - BL'(1);
                        adr_d = adr_q + AW'(BW);
                        if (we_q) begin
                            state_d = S_WDATA;
                        end else begin
                            cyc_d   = 1'b1;
                            state_d = S_WB_REQ;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (cmd_acc_c) begin
                    wdat_d  = bus.wbd_cmd_dat_i;
                    sel_d   = bus.wbd_cmd_sel_i;
                    cyc_d   = 1'b1;
                    state_d = S_WB_REQ;
                end
            end
            S_DRAIN: begin
                // Swallow the rest of an errored write burst without responding
                if (cmd_acc_c) begin
                    rem_d = rem_q - BL'(1);
                    if (rem_q == BL'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                rval_d  = 1'b0;
            end
        endcase
    end

    assign bus.wbs_cyc_o      = cyc_q;
    assign bus.wbs_stb_o      = cyc_q;
    assign bus.wbs_adr_o      = adr_q;
    assign bus.wbs_we_o       = we_q;
    assign bus.wbs_dat_o      = wdat_q;
    assign bus.wbs_sel_o      = sel_q;

    assign bus.wbd_res_rval_o = rval_q;
    assign bus.wbd_res_dat_o  = rdat_q;
    assign bus.wbd_res_ack_o  = rack_q;
    assign bus.wbd_res_lack_o = rlack_q;
    assign bus.wbd_res_err_o  = rerr_q;
    assign bus.wbd_res_tid_o  = rtid_q;
endmodule

// File: tb/tb_wbi_slave_port.sv
// Directed self-checking bench for wbi_slave_port with a zero-wait Wishbone slave model.
// Define WBI_SLV_TIMEOUT_EN to also exercise the WB_REQ watchdog.
module tb_wbi_slave_port;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned BL = 10;
    localparam int unsigned DW = 32;

    logic mclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 mclk = ~mclk;

    wbi_slave_port_if #(.AW(AW), .BW(BW), .BL(BL), .DW(DW)) bus ();

    wbi_slave_port #(.AW(AW), .BW(BW), .BL(BL), .DW(DW)) u_dut (
        .mclk    (mclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Slave model: zero-wait ack, data = address ^ 0x5A5A0000, err injected on access number err_idx
    int acc_cnt = 0;
    int err_idx = -1;
    bit ack_with_err = 1'b0;
    bit slave_en = 1'b1;
    logic stb_c;
    logic err_hit;
    assign stb_c           = bus.wbs_cyc_o & bus.wbs_stb_o;
    assign err_hit         = (acc_cnt == err_idx);
    assign bus.wbs_err_i   = stb_c & slave_en & err_hit;
    assign bus.wbs_ack_i   = stb_c & slave_en & (!err_hit | ack_with_err);
    assign bus.wbs_dat_i   = bus.wbs_adr_o ^ 32'h5A5A_0000;

    typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; } acc_t;
    typedef struct { logic [31:0] dat; logic ack; logic lack; logic err; logic [3:0] tid; } rsp_t;
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    always @(posedge mclk) begin
        if (stb_c && (bus.wbs_ack_i || bus.wbs_err_i)) begin
            acc_q.push_back('{bus.wbs_adr_o, bus.wbs_we_o, bus.wbs_dat_o, bus.wbs_sel_o});
            acc_cnt <= acc_cnt + 1;
        end
        if (bus.wbd_res_rval_o && bus.wbd_res_rrdy_i)
            rsp_q.push_back('{bus.wbd_res_dat_o, bus.wbd_res_ack_o, bus.wbd_res_lack_o,
                              bus.wbd_res_err_o, bus.wbd_res_tid_o});
    end

    task automatic cmd_beat(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                            input logic [3:0] tid, input logic [9:0] bl, input string nm);
        bit ok = 1'b0;
        bus.wbd_cmd_wval_i = 1'b1;
        bus.wbd_cmd_adr_i  = adr;
        bus.wbd_cmd_we_i   = we;
        bus.wbd_cmd_dat_i  = dat;
        bus.wbd_cmd_sel_i  = 4'hF;
        bus.wbd_cmd_tid_i  = tid;
        bus.wbd_cmd_bl_i   = bl;
        for (int i = 0; i < 300; i++) begin
            if (bus.wbd_cmd_wrdy_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge mclk);
        end
        if (ok) @(posedge mclk);
        @(negedge mclk);
        bus.wbd_cmd_wval_i = 1'b0;
        chk_cnt++;
        if (!ok) $display("FAIL %s_accept: wrdy got 0 for 300 cycles, required 1", nm);
        else pass_cnt++;
    endtask

    task automatic wait_rsp(input int n, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rsp_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge mclk);
        end
        chk_cnt++;
        if (!ok) $display("FAIL %s_rsp_wait: got %0d responses, required %0d", nm, rsp_q.size(), n);
        else pass_cnt++;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        rsp_q.delete();
    endtask

    task automatic test_reset();
        bus.wbd_cmd_wval_i = 1'b0;
        bus.wbd_cmd_adr_i  = '0;
        bus.wbd_cmd_we_i   = 1'b0;
        bus.wbd_cmd_dat_i  = '0;
        bus.wbd_cmd_sel_i  = '0;
        bus.wbd_cmd_tid_i  = '0;
        bus.wbd_cmd_bl_i   = '0;
        bus.wbd_res_rrdy_i = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge mclk);
        chk_cnt++;
        if ({bus.wbd_cmd_wrdy_o, bus.wbd_res_rval_o, bus.wbs_cyc_o, bus.wbs_stb_o} !== 4'b0000)
            $display("FAIL rst_ctrl: got %b required 0000",
                     {bus.wbd_cmd_wrdy_o, bus.wbd_res_rval_o, bus.wbs_cyc_o, bus.wbs_stb_o});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.wbd_res_dat_o, bus.wbd_res_ack_o, bus.wbd_res_lack_o, bus.wbd_res_err_o,
             bus.wbd_res_tid_o} !== 39'd0)
            $display("FAIL rst_res: got %h required 0", {bus.wbd_res_dat_o, bus.wbd_res_ack_o,
                     bus.wbd_res_lack_o, bus.wbd_res_err_o, bus.wbd_res_tid_o});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.wbs_adr_o, bus.wbs_we_o, bus.wbs_dat_o, bus.wbs_sel_o} !== 69'd0)
            $display("FAIL rst_wbs: got %h required 0",
                     {bus.wbs_adr_o, bus.wbs_we_o, bus.wbs_dat_o, bus.wbs_sel_o});
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge mclk);
        chk_cnt++;
        if (bus.wbd_cmd_wrdy_o !== 1'b1) $display("FAIL rst_idle_wrdy: got %b required 1", bus.wbd_cmd_wrdy_o);
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        clear_logs();
        cmd_beat(32'h100, 1'b1, 32'hDEAD_BEEF, 4'd3, 10'd1, "wr1");
        chk_cnt++;
        if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_adr_o} !== {2'b11, 32'h100})
            $display("FAIL wr1_stb_timing: got %b%b adr %h required 11 adr 00000100",
                     bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_adr_o);
        else pass_cnt++;
        wait_rsp(1, "wr1");
        chk_cnt++;
        if (acc_q.size() != 1 || {acc_q[0].adr, acc_q[0].we, acc_q[0].dat, acc_q[0].sel}
                                  !== {32'h100, 1'b1, 32'hDEAD_BEEF, 4'hF})
            $display("FAIL wr1_wb_access: got n=%0d adr %h required n=1 adr 00000100 we 1 dat deadbeef sel f",
                     acc_q.size(), (acc_q.size() > 0) ? acc_q[0].adr : 32'hX);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_q.size() > 0 && {rsp_q[0].dat, rsp_q[0].ack, rsp_q[0].lack, rsp_q[0].err, rsp_q[0].tid}
                                === {32'h0, 1'b1, 1'b1, 1'b0, 4'd3}) pass_cnt++;
        else $display("FAIL wr1_rsp: got dat %h ack %b lack %b err %b tid %0d required 0/1/1/0/3",
                      rsp_q[0].dat, rsp_q[0].ack, rsp_q[0].lack, rsp_q[0].err, rsp_q[0].tid);
    endtask

    task automatic test_read_burst();
        logic [31:0] exp_a [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
        logic [31:0] exp_d [4] = '{32'h5A5A_0200, 32'h5A5A_0204, 32'h5A5A_0208, 32'h5A5A_020C};
        clear_logs();
        cmd_beat(32'h200, 1'b0, 32'h0, 4'd5, 10'd4, "rd4");
        wait_rsp(4, "rd4");
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (i < acc_q.size() && {acc_q[i].adr, acc_q[i].we} === {exp_a[i], 1'b0}) pass_cnt++;
            else $display("FAIL rd4_adr%0d: got n=%0d required adr %h read", i, acc_q.size(), exp_a[i]);
            chk_cnt++;
            if (i < rsp_q.size() && {rsp_q[i].dat, rsp_q[i].ack, rsp_q[i].lack, rsp_q[i].err, rsp_q[i].tid}
                                    === {exp_d[i], 1'b1, (i == 3), 1'b0, 4'd5}) pass_cnt++;
            else $display("FAIL rd4_rsp%0d: got n=%0d required dat %h lack %0d tid 5",
                          i, rsp_q.size(), exp_d[i], (i == 3));
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        int bad = 0;
        clear_logs();
        bus.wbd_res_rrdy_i = 1'b0;
        cmd_beat(32'h300, 1'b0, 32'h0, 4'd7, 10'd2, "bp");
        for (int i = 0; i < 50; i++) begin
            if (bus.wbd_res_rval_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge mclk);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge mclk);
            if (bus.wbd_res_rval_o !== 1'b1 || bus.wbd_res_dat_o !== 32'h5A5A_0300 ||
                bus.wbd_res_lack_o !== 1'b0 || bus.wbs_stb_o !== 1'b0) bad++;
        end
        chk_cnt++;
        if (!seen || bad != 0) $display("FAIL bp_hold: rval_seen %0d unstable_cycles %0d required 1 and 0", seen, bad);
        else pass_cnt++;
        bus.wbd_res_rrdy_i = 1'b1;
        wait_rsp(2, "bp");
        chk_cnt++;
        if (rsp_q.size() == 2 && {rsp_q[0].dat, rsp_q[0].lack, rsp_q[1].dat, rsp_q[1].lack, rsp_q[1].tid}
                                 === {32'h5A5A_0300, 1'b0, 32'h5A5A_0304, 1'b1, 4'd7}) pass_cnt++;
        else $display("FAIL bp_rsp: got n=%0d required 5a5a0300/lack0 then 5a5a0304/lack1 tid 7", rsp_q.size());
        chk_cnt++;
        if (acc_q.size() == 2 && acc_q[1].adr === 32'h304) pass_cnt++;
        else $display("FAIL bp_acc: got n=%0d required 2 with second adr 00000304", acc_q.size());
    endtask

    task automatic test_write_err();
        clear_logs();
        err_idx = acc_cnt + 1;
        cmd_beat(32'h400, 1'b1, 32'h1111_1111, 4'd9, 10'd3, "werr_b1");
        cmd_beat(32'hFFF0, 1'b0, 32'h2222_2222, 4'd1, 10'd7, "werr_b2");
        cmd_beat(32'hFFF0, 1'b0, 32'h3333_3333, 4'd1, 10'd7, "werr_b3");
        wait_rsp(2, "werr");
        repeat (20) @(negedge mclk);
        err_idx = -1;
        chk_cnt++;
        if (rsp_q.size() == 2 && acc_q.size() == 2) pass_cnt++;
        else $display("FAIL werr_counts: got rsp %0d acc %0d required 2 and 2", rsp_q.size(), acc_q.size());
        chk_cnt++;
        if (rsp_q.size() >= 2 &&
            {rsp_q[0].ack, rsp_q[0].lack, rsp_q[0].err, rsp_q[0].tid, rsp_q[0].dat} === {3'b100, 4'd9, 32'h0} &&
            {rsp_q[1].ack, rsp_q[1].lack, rsp_q[1].err, rsp_q[1].tid} === {3'b011, 4'd9}) pass_cnt++;
        else $display("FAIL werr_rsp: got n=%0d required ack/lack/err 100 then 011 tid 9", rsp_q.size());
        chk_cnt++;
        if (acc_q.size() >= 2 && {acc_q[1].adr, acc_q[1].we, acc_q[1].dat} === {32'h404, 1'b1, 32'h2222_2222})
            pass_cnt++;
        else $display("FAIL werr_acc2: got n=%0d required adr 00000404 we 1 dat 22222222", acc_q.size());
        // A fresh read completing proves the port went back to IDLE after the drain
        clear_logs();
        cmd_beat(32'h500, 1'b0, 32'h0, 4'd6, 10'd1, "werr_idle");
        wait_rsp(1, "werr_idle");
        chk_cnt++;
        if (rsp_q.size() == 1 && {rsp_q[0].dat, rsp_q[0].ack, rsp_q[0].lack, rsp_q[0].tid}
                                 === {32'h5A5A_0500, 1'b1, 1'b1, 4'd6}) pass_cnt++;
        else $display("FAIL werr_idle_rd: got n=%0d required dat 5a5a0500 ack 1 lack 1 tid 6", rsp_q.size());
    endtask

    task automatic test_ack_and_err();
        clear_logs();
        ack_with_err = 1'b1;
        err_idx = acc_cnt;
        cmd_beat(32'h600, 1'b0, 32'h0, 4'd2, 10'd3, "ackerr");
        wait_rsp(1, "ackerr");
        repeat (10) @(negedge mclk);
        err_idx = -1;
        ack_with_err = 1'b0;
        chk_cnt++;
        if (rsp_q.size() == 1 && acc_q.size() == 1 &&
            {rsp_q[0].dat, rsp_q[0].ack, rsp_q[0].lack, rsp_q[0].err, rsp_q[0].tid}
            === {32'h5A5A_0600, 1'b0, 1'b1, 1'b1, 4'd2}) pass_cnt++;
        else $display("FAIL ackerr_rsp: got rsp %0d acc %0d required 1/1 dat 5a5a0600 ack 0 lack 1 err 1",
                      rsp_q.size(), acc_q.size());
    endtask

    task automatic test_wrap();
        clear_logs();
        cmd_beat(32'hFFFF_FFFC, 1'b0, 32'h0, 4'd1, 10'd2, "wrap");
        wait_rsp(2, "wrap");
        chk_cnt++;
        if (acc_q.size() == 2 && acc_q[0].adr === 32'hFFFF_FFFC && acc_q[1].adr === 32'h0000_0000) pass_cnt++;
        else $display("FAIL wrap_adr: got n=%0d required fffffffc then 00000000", acc_q.size());
        chk_cnt++;
        if (rsp_q.size() == 2 && {rsp_q[0].dat, rsp_q[1].dat, rsp_q[1].lack} === {32'hA5A5_FFFC, 32'h5A5A_0000, 1'b1})
            pass_cnt++;
        else $display("FAIL wrap_rsp: got n=%0d required a5a5fffc then 5a5a0000 lack 1", rsp_q.size());
    endtask

    task automatic test_bl_zero();
        clear_logs();
        cmd_beat(32'h700, 1'b0, 32'h0, 4'd8, 10'd0, "bl0");
        wait_rsp(1, "bl0");
        repeat (8) @(negedge mclk);
        chk_cnt++;
        if (acc_q.size() == 1 && rsp_q.size() == 1 && {rsp_q[0].dat, rsp_q[0].lack, rsp_q[0].tid}
                                                     === {32'h5A5A_0700, 1'b1, 4'd8}) pass_cnt++;
        else $display("FAIL bl0: got acc %0d rsp %0d required 1 access, 1 response with lack 1", acc_q.size(), rsp_q.size());
    endtask

`ifdef WBI_SLV_TIMEOUT_EN
    task automatic test_timeout();
        int cyc_cycles = 0;
        clear_logs();
        slave_en = 1'b0;
        cmd_beat(32'h800, 1'b0, 32'h0, 4'd4, 10'd1, "tmo");
        for (int i = 0; i < 400; i++) begin
            if (!bus.wbs_cyc_o) break;
            cyc_cycles++;
            @(negedge mclk);
        end
        chk_cnt++;
        if (cyc_cycles != 256 || bus.wbs_stb_o !== 1'b0)
            $display("FAIL tmo_cyc: got %0d cycles high stb %b required 256 then 0", cyc_cycles, bus.wbs_stb_o);
        else pass_cnt++;
        wait_rsp(1, "tmo");
        slave_en = 1'b1;
        chk_cnt++;
        if (rsp_q.size() == 1 && {rsp_q[0].dat, rsp_q[0].ack, rsp_q[0].lack, rsp_q[0].err, rsp_q[0].tid}
                                 === {32'h0, 1'b0, 1'b1, 1'b1, 4'd4}) pass_cnt++;
        else $display("FAIL tmo_rsp: got n=%0d required dat 0 ack 0 lack 1 err 1 tid 4", rsp_q.size());
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_backpressure();
        test_write_err();
        test_ack_and_err();
        test_wrap();
        test_bl_zero();
`ifdef WBI_SLV_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
